uart_receiver: RTL and testbench

Parametrised UART receive engine, the next generation of the team's serial receiver. It adds an asynchronous active-low reset, a 2-flop input synchroniser, 3-sample majority voting, optional parity, 1 or 2 stop bits, false-start rejection, and framing, parity and break reporting. It sits between the pad-side `rx_in` line and the byte-level consumer, clocked by the system clock and paced by the shared baud-oversample `tick` strobe.

---
 rtl/uart_receiver.sv | 258 +++++++++++++++++++++++++
 tb/tb_uart_receiver.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : Oversampled UART receive engine with 2-flop synchroniser,
//               3-sample majority vote, framing/parity/break reporting.
//               Optional parity selected by defining UART_RX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver #(
  parameter int DATA_WIDTH      = 8,
  parameter int OVERSAMPLE_RATE = 16,
  parameter int STOP_BITS       = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  rx_in,
  input  logic                  parity_odd,
  output logic [DATA_WIDTH-1:0] rx_out,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  break_det,
  output logic                  busy
);

  localparam int c_CNT_W = $clog2(OVERSAMPLE_RATE);
  localparam int c_IDX_W = $clog2(DATA_WIDTH + 1);

  localparam logic [c_CNT_W-1:0] c_SAMP0     = c_CNT_W'(OVERSAMPLE_RATE / 2 - 2);
  localparam logic [c_CNT_W-1:0] c_SAMP1     = c_CNT_W'(OVERSAMPLE_RATE / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_MID       = c_CNT_W'(OVERSAMPLE_RATE / 2);
  localparam logic [c_CNT_W-1:0] c_LAST      = c_CNT_W'(OVERSAMPLE_RATE - 1);
  localparam logic [c_IDX_W-1:0] c_LAST_DATA = c_IDX_W'(DATA_WIDTH - 1);
  localparam logic [c_IDX_W-1:0] c_LAST_STOP = c_IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd3,
`endif
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic                  r_sync1;
  logic                  r_sync2;
  logic                  w_rxs;

  logic [c_CNT_W-1:0]    r_tick_cnt;
  logic [c_IDX_W-1:0]    r_idx;
  logic [1:0]            r_samp;
  logic [DATA_WIDTH-1:0] r_shadow;

  logic                  r_all_zero;
  logic                  r_first_stop_zero;
  logic                  r_stop_fail;
`ifdef UART_RX_PARITY_EN
  logic                  r_par_fail;
`else
  logic                  w_unused_parity_odd;
`endif

  logic [DATA_WIDTH-1:0] r_rx_out;
  logic                  r_rx_valid;
  logic                  r_frame_err;
  logic                  r_parity_err;
  logic                  r_break_det;

  logic                  w_active;
  logic                  w_mid;
  logic                  w_wrap;
  logic                  w_vote;
  logic                  w_finish;
  logic                  w_first_stop_zero;

  // Pad input is asynchronous; both flops idle high so reset never looks like a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs    = r_sync2;
  assign w_active = (r_state != S_IDLE) && (r_state != S_WAIT_HIGH);
  assign w_mid    = w_active && tick && (r_tick_cnt == c_MID);
  assign w_wrap   = w_active && tick && (r_tick_cnt == c_LAST);
  assign w_vote   = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rxs) | (r_samp[1] & w_rxs);

  assign w_first_stop_zero = (r_idx == '0) ? ~w_vote : r_first_stop_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_next_state = S_START;
        end
      end
      S_START: begin
        if (w_mid && w_vote) begin
          w_next_state = S_IDLE;
        end else if (w_wrap) begin
          w_next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (w_wrap && (r_idx == c_LAST_DATA)) begin
`ifdef UART_RX_PARITY_EN
          w_next_state = S_PARITY;
`else
          w_next_state = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_wrap) begin
          w_next_state = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Leave at mid-bit of the last stop so a back-to-back start edge is not missed.
        if (w_mid && (r_idx == c_LAST_STOP)) begin
          w_finish     = 1'b1;
          w_next_state = (!r_stop_fail && w_vote) ? S_IDLE : S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        if (w_rxs) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
      r_idx      <= '0;
      r_samp     <= '0;
    end else begin
      if (w_next_state != r_state) begin
        r_tick_cnt <= '0;
        r_idx      <= '0;
      end else if (w_active && tick) begin
        r_tick_cnt <= w_wrap ? '0 : r_tick_cnt + c_CNT_W'(1);
        if (w_wrap) begin
          r_idx <= r_idx + c_IDX_W'(1);
        end
      end
      if (w_active && tick) begin
        if (r_tick_cnt == c_SAMP0) r_samp[0] <= w_rxs;
        if (r_tick_cnt == c_SAMP1) r_samp[1] <= w_rxs;
      end
    end
  end

  // Per-frame accumulators; cleared while idle, updated on each mid-bit vote.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow          <= '0;
      r_all_zero        <= 1'b1;
      r_first_stop_zero <= 1'b0;
      r_stop_fail       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_fail        <= 1'b0;
`endif
    end else if (r_state == S_IDLE) begin
      r_all_zero        <= 1'b1;
      r_first_stop_zero <= 1'b0;
      r_stop_fail       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_fail        <= 1'b0;
`endif
    end else if (w_mid) begin
      case (r_state)
        S_DATA: begin
          for (int i = 0; i < DATA_WIDTH; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
              r_shadow[i] <= w_vote;
            end
          end
          if (w_vote) r_all_zero <= 1'b0;
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_vote) r_all_zero <= 1'b0;
          r_par_fail <= w_vote ^ (^r_shadow) ^ parity_odd;
        end
`endif
        S_STOP: begin
          if (!w_vote) r_stop_fail <= 1'b1;
          if (r_idx == '0) r_first_stop_zero <= ~w_vote;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_out     <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_break_det  <= 1'b0;
    end else begin
      r_rx_valid <= w_finish;
      if (w_finish) begin
        r_rx_out    <= r_shadow;
        r_frame_err <= r_stop_fail | ~w_vote;
        r_break_det <= r_all_zero & w_first_stop_zero;
`ifdef UART_RX_PARITY_EN
        r_parity_err <= r_par_fail;
`else
        r_parity_err <= 1'b0;
`endif
      end
    end
  end

`ifndef UART_RX_PARITY_EN
  assign w_unused_parity_odd = parity_odd;
`endif

  assign rx_out     = r_rx_out;
  assign rx_valid   = r_rx_valid;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign break_det  = r_break_det;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_receiver
// Description : Self-checking bench for uart_receiver, directed and random
//               frames checked against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

  localparam int DW = 8;
  localparam int OS = 16;
  localparam int SB = 1;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LAT = (DW + P + SB) * OS + OS / 2 + 1;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          fe;
    logic          pe;
    logic          brk;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic          rx_in = 1'b1;
  logic          parity_odd = 1'b0;
  logic [DW-1:0] rx_out;
  logic          rx_valid;
  logic          frame_err;
  logic          parity_err;
  logic          break_det;
  logic          busy;

  always #5 clk = ~clk;

  uart_receiver #(
    .DATA_WIDTH      (DW),
    .OVERSAMPLE_RATE (OS),
    .STOP_BITS       (SB)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .rx_in      (rx_in),
    .parity_odd (parity_odd),
    .rx_out     (rx_out),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .break_det  (break_det),
    .busy       (busy)
  );

  int total = 0;
  int bad = 0;

  // Observation of output pulses, latency in ticks and busy fall points.
  int            nvalid = 0;
  int            dbl = 0;
  int            tcnt = 0;
  int            lat = 0;
  int            fall_ticks = -1;
  logic          prev_busy = 1'b0;
  logic          prev_valid = 1'b0;
  logic [DW-1:0] cap_data = '0;
  logic          cap_fe = 1'b0;
  logic          cap_pe = 1'b0;
  logic          cap_brk = 1'b0;
  logic          cap_busy = 1'b0;

  always @(negedge clk) begin
    if (rx_valid) begin
      nvalid   = nvalid + 1;
      lat      = tcnt;
      cap_data = rx_out;
      cap_fe   = frame_err;
      cap_pe   = parity_err;
      cap_brk  = break_det;
      cap_busy = busy;
      if (prev_valid) dbl = dbl + 1;
    end
    if (prev_busy && !busy) fall_ticks = tcnt;
    if (!busy) tcnt = 0;
    else if (tick) tcnt = tcnt + 1;
    prev_busy  = busy;
    prev_valid = rx_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step_tick();
    repeat (3) @(posedge clk);
    #1 tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
  endtask

  function automatic exp_t model(input logic [DW-1:0] d, input logic pbit,
                                 input logic [1:0] stops, input logic podd);
    exp_t e;
    e.d  = d;
    e.fe = 1'b0;
    for (int i = 0; i < SB; i++) if (!stops[i]) e.fe = 1'b1;
    e.pe  = (P == 1) ? (pbit != ((^d) ^ podd)) : 1'b0;
    e.brk = (d == '0) && (P == 0 || pbit == 1'b0) && !stops[0];
    return e;
  endfunction

  // Drive one frame, OS ticks per bit. gbit/gk invert one of the three
  // mid-bit samples of line bit gbit; rbit aborts with reset inside that bit.
  task automatic send_frame(input logic [DW-1:0] d, input logic pbit, input logic [1:0] stops,
                            input int gbit, input int gk, input int rbit);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (P == 1) bits.push_back(pbit);
    for (int i = 0; i < SB; i++) bits.push_back(stops[i]);
    for (int b = 0; b < bits.size(); b++) begin
      for (int t = 1; t <= OS; t++) begin
        if (b == rbit && t == 4) begin
          rst_n = 1'b0;
          #2;
          check("rst_mid.rx_out", rx_out, '0);
          check("rst_mid.rx_valid", rx_valid, 1'b0);
          check("rst_mid.frame_err", frame_err, 1'b0);
          check("rst_mid.parity_err", parity_err, 1'b0);
          check("rst_mid.break_det", break_det, 1'b0);
          check("rst_mid.busy", busy, 1'b0);
          rx_in = 1'b1;
          repeat (3) @(posedge clk);
          #1 rst_n = 1'b1;
          repeat (4) step_tick();
          return;
        end
        rx_in = bits[b] ^ ((b == gbit) && (t == 7 + gk));
        step_tick();
      end
    end
    rx_in = 1'b1;
    repeat (4) step_tick();
  endtask

  task automatic check_rx(input string tag, input exp_t e, input int nv0);
    check({tag, ".nvalid"}, nvalid - nv0, 1);
    check({tag, ".rx_out"}, cap_data, e.d);
    check({tag, ".frame_err"}, cap_fe, e.fe);
    check({tag, ".parity_err"}, cap_pe, e.pe);
    check({tag, ".break_det"}, cap_brk, e.brk);
    check({tag, ".busy_at_valid"}, cap_busy, e.fe);
    check({tag, ".latency"}, lat, LAT);
  endtask

  initial begin
    int            nv0;
    exp_t          e;
    logic [DW-1:0] d;
    logic          pb;
    logic [1:0]    st;
    int            gb;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.rx_out", rx_out, '0);
    check("reset.rx_valid", rx_valid, 1'b0);
    check("reset.frame_err", frame_err, 1'b0);
    check("reset.parity_err", parity_err, 1'b0);
    check("reset.break_det", break_det, 1'b0);
    check("reset.busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (8) step_tick();

    // Clean 0xA5 with correct parity.
    parity_odd = 1'b0;
    nv0 = nvalid;
    send_frame(8'hA5, ^8'hA5, 2'b11, -1, 0, -1);
    check_rx("a5", model(8'hA5, ^8'hA5, 2'b11, 1'b0), nv0);

    // One of the three samples of data bit 3 inverted.
    nv0 = nvalid;
    send_frame(8'hA5, ^8'hA5, 2'b11, 4, int'($urandom_range(0, 2)), -1);
    check_rx("a5_glitch", model(8'hA5, ^8'hA5, 2'b11, 1'b0), nv0);

    // Stop bit driven low: frame error, WAIT_HIGH, then idle once line is high.
    nv0 = nvalid;
    send_frame(8'h3C, ^8'h3C, 2'b10, -1, 0, -1);
    check_rx("stop0", model(8'h3C, ^8'h3C, 2'b10, 1'b0), nv0);
    check("stop0.busy_after_high", busy, 1'b0);

    // False start: low 4 ticks; flags from the previous frame must hold.
    nv0 = nvalid;
    fall_ticks = -1;
    rx_in = 1'b0;
    repeat (4) step_tick();
    rx_in = 1'b1;
    repeat (2 * OS) step_tick();
    check("false_start.nvalid", nvalid - nv0, 0);
    check("false_start.busy_fall_tick", fall_ticks, OS / 2 + 1);
    check("false_start.frame_err_held", frame_err, 1'b1);
    check("false_start.rx_out_held", rx_out, 8'h3C);

`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
    nv0 = nvalid;
    send_frame(8'h07, 1'b0, 2'b11, -1, 0, -1);
    check_rx("par_bad", model(8'h07, 1'b0, 2'b11, 1'b0), nv0);
    nv0 = nvalid;
    send_frame(8'h07, 1'b1, 2'b11, -1, 0, -1);
    check_rx("par_good", model(8'h07, 1'b1, 2'b11, 1'b0), nv0);
`endif

    // Line break for 20 bit times, then recovery.
    nv0 = nvalid;
    rx_in = 1'b0;
    repeat (20 * OS) step_tick();
    e = model('0, 1'b0, 2'b00, parity_odd);
    check("break.nvalid", nvalid - nv0, 1);
    check("break.rx_out", cap_data, e.d);
    check("break.frame_err", cap_fe, e.fe);
    check("break.break_det", cap_brk, e.brk);
    check("break.latency", lat, LAT);
    check("break.busy_while_low", busy, 1'b1);
    rx_in = 1'b1;
    repeat (4) step_tick();
    check("break.busy_after_high", busy, 1'b0);
    nv0 = nvalid;
    send_frame(8'h5A, ^8'h5A ^ parity_odd, 2'b11, -1, 0, -1);
    check_rx("after_break", model(8'h5A, ^8'h5A ^ parity_odd, 2'b11, parity_odd), nv0);

    // Reset during data bit 4 (line bit 5), then a clean frame.
    nv0 = nvalid;
    send_frame(8'h5A, ^8'h5A ^ parity_odd, 2'b11, -1, 0, 5);
    check("rst_mid.nvalid", nvalid - nv0, 0);
    nv0 = nvalid;
    send_frame(8'h5A, ^8'h5A ^ parity_odd, 2'b11, -1, 0, -1);
    check_rx("after_rst", model(8'h5A, ^8'h5A ^ parity_odd, 2'b11, parity_odd), nv0);

    // Random frames: data, parity bit, occasional bad stop, single-sample glitch.
    for (int n = 0; n < 10; n++) begin
      d          = DW'($urandom);
      pb         = 1'($urandom);
      parity_odd = 1'($urandom);
      st         = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
      gb         = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, DW + P + SB));
      nv0 = nvalid;
      send_frame(d, pb, st, gb, int'($urandom_range(0, 2)), -1);
      check_rx($sformatf("rand%0d", n), model(d, pb, st, parity_odd), nv0);
    end

    check("rx_valid_single_cycle", dbl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
